// File: rtl/store_buffer.sv
// store_buffer: small write-posting FIFO in front of data memory.
// Stores are queued in a DEPTH-entry FIFO and drained one at a time through a
// two-state request/acknowledge handshake. If a write is not acknowledged within
// TIMEOUT cycles, it is dropped and a sticky error flag is raised.
module store_buffer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  output logic        st_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        err_clr,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [WW-1:0] wait_reg;

  logic [15:0] addr_mem [DEPTH];
  logic [15:0] data_mem [DEPTH];

  logic push;
  logic pop;
  logic timeout_hit;

  // Room is judged from the registered count only, so a pop cannot make room
  // for a push at the same edge.
  assign st_ready    = (count_reg < FULL_CNT);
  assign push        = st & st_ready;
  // An ack arriving on the final wait cycle wins over the timeout.
  assign timeout_hit = (state_reg == REQ) & ~mem_ack & (wait_reg == LAST_WAIT);
  assign pop         = (state_reg == REQ) & (mem_ack | timeout_hit);
  assign busy        = (count_reg != '0) | (state_reg == REQ);

  // Entry storage: written on accepted stores, never reset (pointers define validity).
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= st_addr;
      data_mem[wr_ptr_reg] <= st_data;
    end
  end

  // FIFO bookkeeping, error flag and the IDLE/REQ handshake with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      wait_reg   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase

      // A new timeout takes priority over a simultaneous clear request.
      if (timeout_hit) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          // mem_ack is deliberately ignored here.
          if (count_reg != '0) begin
            state_reg <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr_mem[rd_ptr_reg];
            mem_wdata <= data_mem[rd_ptr_reg];
            wait_reg  <= '0;
          end
        end
        REQ: begin
          if (pop) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + WW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: transaction-level queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st = 1'b0;
  logic [15:0] st_addr = '0;
  logic [15:0] st_data = '0;
  logic        mem_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic        st_ready, mem_req, mem_we, err, busy;
  logic [15:0] mem_addr, mem_wdata;

  store_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .st(st), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .err_clr(err_clr), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending stores as a queue; the head is "in flight" once a transaction starts.
  // A transaction times out when TIMEOUT edges have passed since it started.
  typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
  ent_t   mq[$];
  bit     m_active = 1'b0;
  bit     m_err = 1'b0;
  longint cyc = 0;
  longint start_cyc = 0;

  always @(posedge clk or negedge rst) begin
    bit accept;
    bit timed;
    if (!rst) begin
      mq.delete();
      m_active = 1'b0;
      m_err = 1'b0;
    end else begin
      accept = st && (mq.size() < DEPTH);
      timed = 1'b0;
      cyc++;
      if (m_active) begin
        if (mem_ack) begin
          void'(mq.pop_front());
          m_active = 1'b0;
        end else if (cyc - start_cyc == TIMEOUT) begin
          void'(mq.pop_front());
          m_active = 1'b0;
          m_err = 1'b1;
          timed = 1'b1;
        end
      end else if (mq.size() > 0) begin
        m_active = 1'b1;
        start_cyc = cyc;
      end
      if (!timed && err_clr) m_err = 1'b0;
      if (accept) mq.push_back({st_addr, st_data});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
    chk("cyc_mem_req", 32'(mem_req), 32'(m_active));
    chk("cyc_mem_we", 32'(mem_we), 32'(m_active));
    chk("cyc_err", 32'(err), 32'(m_err));
    chk("cyc_busy", 32'(busy), 32'((mq.size() > 0) || m_active));
    if (m_active && mq.size() > 0) begin
      chk("cyc_mem_addr_data", {mem_addr, mem_wdata}, mq[0]);
    end
  end

  // Log of completed writes observed on the memory side.
  logic [31:0] wlog[$];
  always @(posedge clk) begin
    if (rst && mem_req && mem_ack) begin
      wlog.push_back({mem_addr, mem_wdata});
      $display("write addr=0x%04h data=0x%04h t=%0t", mem_addr, mem_wdata, $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    st = 1'b1; st_addr = a; st_data = d;
    step();
    st = 1'b0;
  endtask

  initial begin
    int base;
    int hi;
    logic [31:0] exp6 [5];

    // Reset state
    step(); step();
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b1;
    step();

    // Single store with ack two cycles after mem_req
    store(16'h0010, 16'hABCD);
    chk("t1_busy_after_push", 32'(busy), 32'd1);
    chk("t1_req_not_yet", 32'(mem_req), 32'd0);
    step();
    chk("t1_req_latency", 32'(mem_req), 32'd1);
    chk("t1_addr_data", {mem_addr, mem_wdata}, 32'h0010ABCD);
    step(); step();
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("t1_busy_after_ack", 32'(busy), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_write_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) chk("t1_write_value", wlog[0], 32'h0010ABCD);

    // Fill: five stores with no ack, then drain
    base = wlog.size();
    for (int i = 0; i < 5; i++) store(16'(16'h0100 + i), 16'(16'h1000 + i));
    chk("t2_full_not_ready", 32'(st_ready), 32'd0);
    chk("t2_head_addr", 32'(mem_addr), 32'h0100);
    mem_ack = 1'b1;
    step();
    chk("t2_gap_idle", 32'(mem_req), 32'd0);
    step();
    chk("t2_gap_next", 32'(mem_req), 32'd1);
    chk("t2_next_addr", 32'(mem_addr), 32'h0101);
    repeat (6) step();
    mem_ack = 1'b0;
    chk("t2_write_count", 32'(wlog.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < wlog.size())
        chk($sformatf("t2_order%0d", i), wlog[base + i], {16'(16'h0100 + i), 16'(16'h1000 + i)});
    end
    chk("t2_busy_drained", 32'(busy), 32'd0);

    // Timeout: no ack, mem_req high for exactly TIMEOUT cycles
    base = wlog.size();
    store(16'h0020, 16'h1234);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req) hi++;
    end
    chk("t3_req_cycles", 32'(hi), 32'd15);
    chk("t3_err_set", 32'(err), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_no_write", 32'(wlog.size() - base), 32'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t3_err_cleared", 32'(err), 32'd0);

    // Ack on the 15th REQ cycle counts as success
    store(16'h0030, 16'h5678);
    step();
    chk("t4_req", 32'(mem_req), 32'd1);
    repeat (14) step();
    chk("t4_still_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_req_done", 32'(mem_req), 32'd0);
    if (wlog.size() >= 1) chk("t4_write", wlog[wlog.size() - 1], 32'h00305678);

    // err_clr coinciding with a timeout leaves err set
    store(16'h0040, 16'h9999);
    step();
    repeat (14) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t5_err_kept", 32'(err), 32'd1);
    chk("t5_req_dropped", 32'(mem_req), 32'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t5_err_cleared", 32'(err), 32'd0);

    // Full with simultaneous ack and store: store rejected, next one accepted
    base = wlog.size();
    for (int i = 0; i < 4; i++) store(16'(16'h0200 + i), 16'(16'h2000 + i));
    chk("t6_full", 32'(st_ready), 32'd0);
    st = 1'b1; st_addr = 16'hDEAD; st_data = 16'hDEAD; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t6_room_after_pop", 32'(st_ready), 32'd1);
    st_addr = 16'h0250; st_data = 16'h2050;
    step();
    st = 1'b0;
    chk("t6_full_again", 32'(st_ready), 32'd0);
    mem_ack = 1'b1; repeat (10) step(); mem_ack = 1'b0;
    exp6[0] = 32'h02002000; exp6[1] = 32'h02012001; exp6[2] = 32'h02022002;
    exp6[3] = 32'h02032003; exp6[4] = 32'h02502050;
    chk("t6_write_count", 32'(wlog.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < wlog.size()) chk($sformatf("t6_order%0d", i), wlog[base + i], exp6[i]);
    end

    // Asynchronous reset in the middle of a transaction
    base = wlog.size();
    store(16'h0300, 16'h3000);
    step();
    chk("t7_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t7_async_req", 32'(mem_req), 32'd0);
    chk("t7_async_busy", 32'(busy), 32'd0);
    chk("t7_async_ready", 32'(st_ready), 32'd1);
    chk("t7_async_addr", 32'(mem_addr), 32'd0);
    step();
    rst = 1'b1;
    mem_ack = 1'b1; repeat (4) step(); mem_ack = 1'b0;
    chk("t7_no_write", 32'(wlog.size() - base), 32'd0);
    chk("t7_req_idle", 32'(mem_req), 32'd0);
    chk("t7_busy_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
